// File: rtl/fb_pkg.sv
// Shared constants and state encoding for the framebuffer text write path.
package fb_pkg;
  localparam int FB_COLS       = 80;
  localparam int FB_ROWS       = 60;
  localparam int FB_LINE_WORDS = 80;
  localparam int FB_CLR_WORDS  = FB_COLS * FB_ROWS * 2;
  localparam int FB_ADDR_W     = 14;
  localparam int FB_DATA_W     = 32;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WR0,
    WR1,
    CLEAR
  } fb_wr_state_t;
endpackage

// File: rtl/fb_font_rom.sv
// 128-glyph x 8-row font ROM, leftmost pixel in the MSB, registered read data.
module fb_font_rom (
  input  logic       clk,
  input  logic [9:0] addr,
  output logic [7:0] data
);
  // Glyphs not listed here read back as blank cells.
  function automatic logic [7:0] glyph_row(input logic [9:0] a);
    case (a)
      {7'h48, 3'd1}, {7'h48, 3'd2}, {7'h48, 3'd4},
      {7'h48, 3'd5}, {7'h48, 3'd6}: glyph_row = 8'hCC;
      {7'h48, 3'd3}:                glyph_row = 8'hFC;
      {7'h49, 3'd1}, {7'h49, 3'd6}: glyph_row = 8'h78;
      {7'h49, 3'd2}, {7'h49, 3'd3},
      {7'h49, 3'd4}, {7'h49, 3'd5}: glyph_row = 8'h30;
      default:                      glyph_row = 8'h00;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    data <= glyph_row(addr);
  end
endmodule

// File: rtl/fb_text_writer.sv
// Sole write-port controller of the text framebuffer RAM: draws 8x8 glyph
// cells fetched from the font ROM and clears the whole screen on request.
module fb_text_writer
  import fb_pkg::*;
#(
  parameter int COLS       = FB_COLS,
  parameter int ROWS       = FB_ROWS,
  parameter int LINE_WORDS = FB_LINE_WORDS
) (
  input  logic        CLK_25,
  input  logic        Reset,
  input  logic        chr_valid,
  output logic        chr_ready,
  input  logic [6:0]  chr_code,
  input  logic [6:0]  chr_col,
  input  logic [5:0]  chr_row,
  input  logic        clr_valid,
  output logic        clr_ready,
  output logic        busy,
  output logic        err,
  output logic        WrEn,
  output logic [13:0] WrAddress,
  output logic [31:0] WrData
);
  localparam logic [6:0]  COL_LIM   = 7'(COLS);
  localparam logic [5:0]  ROW_LIM   = 6'(ROWS);
  localparam logic [13:0] LW        = 14'(LINE_WORDS);
  localparam logic [13:0] CELL_ROW  = 14'(2 * LINE_WORDS);
  localparam logic [13:0] CLR_LAST  = 14'(COLS * ROWS * 2 - 1);

  fb_wr_state_t state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic [13:0] clr_cnt, clr_cnt_nxt;
  logic [6:0]  code_r, col_r;
  logic [5:0]  row_r;
  logic [7:0]  rowbuf [8];
  logic [7:0]  rom_q;
  logic [13:0] w0;
  logic        chr_fire, clr_fire, in_range;
  logic        wr_en_nxt, err_nxt;
  logic [13:0] wr_addr_nxt;
  logic [31:0] wr_data_nxt;

  function automatic logic [7:0] rev8(input logic [7:0] b);
    for (int j = 0; j < 8; j++) rev8[j] = b[7-j];
  endfunction

  // Byte k of a RAM word is line k of the band, pixel 0 in bit 0.
  function automatic logic [31:0] pack4(input logic [7:0] r0, input logic [7:0] r1,
                                        input logic [7:0] r2, input logic [7:0] r3);
    return {rev8(r3), rev8(r2), rev8(r1), rev8(r0)};
  endfunction

  assign clr_ready = (state == IDLE);
  assign chr_ready = (state == IDLE) && !clr_valid;
  assign busy      = (state != IDLE);
  assign chr_fire  = chr_valid && chr_ready;
  assign clr_fire  = clr_valid && clr_ready;
  assign in_range  = (chr_col < COL_LIM) && (chr_row < ROW_LIM);
  assign w0        = {8'd0, row_r} * CELL_ROW + {7'd0, col_r};

  fb_font_rom u_rom (
    .clk  (CLK_25),
    .addr ({code_r, cnt[2:0]}),
    .data (rom_q)
  );

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    clr_cnt_nxt = clr_cnt;
    wr_en_nxt   = 1'b0;
    wr_addr_nxt = '0;
    wr_data_nxt = '0;
    err_nxt     = 1'b0;
    case (state)
      IDLE: begin
        if (clr_fire) begin
          state_nxt   = CLEAR;
          clr_cnt_nxt = '0;
          wr_en_nxt   = 1'b1;
        end else if (chr_fire) begin
          if (in_range) begin
            state_nxt = FETCH;
            cnt_nxt   = '0;
          end else begin
            err_nxt = 1'b1;
          end
        end
      end
      FETCH: begin
        // Rows 0..3 are already buffered when the last fetch cycle ends.
        if (cnt == 4'd8) begin
          state_nxt   = WR0;
          wr_en_nxt   = 1'b1;
          wr_addr_nxt = w0;
          wr_data_nxt = pack4(rowbuf[0], rowbuf[1], rowbuf[2], rowbuf[3]);
        end else begin
          cnt_nxt = cnt + 4'd1;
        end
      end
      WR0: begin
        state_nxt   = WR1;
        wr_en_nxt   = 1'b1;
        wr_addr_nxt = w0 + LW;
        wr_data_nxt = pack4(rowbuf[4], rowbuf[5], rowbuf[6], rowbuf[7]);
      end
      WR1: state_nxt = IDLE;
      CLEAR: begin
        if (clr_cnt == CLR_LAST) begin
          state_nxt = IDLE;
        end else begin
          clr_cnt_nxt = clr_cnt + 14'd1;
          wr_en_nxt   = 1'b1;
          wr_addr_nxt = clr_cnt + 14'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK_25 or posedge Reset) begin
    if (Reset) begin
      state     <= IDLE;
      cnt       <= '0;
      clr_cnt   <= '0;
      WrEn      <= 1'b0;
      WrAddress <= '0;
      WrData    <= '0;
      err       <= 1'b0;
      for (int i = 0; i < 8; i++) rowbuf[i] <= '0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      clr_cnt   <= clr_cnt_nxt;
      WrEn      <= wr_en_nxt;
      WrAddress <= wr_addr_nxt;
      WrData    <= wr_data_nxt;
      err       <= err_nxt;
      // ROM data lags its address by one cycle, so count c delivers row c-1.
      if (state == FETCH && cnt != 4'd0) rowbuf[3'(cnt - 4'd1)] <= rom_q;
    end
  end

  always_ff @(posedge CLK_25) begin
    if (chr_fire && in_range) begin
      code_r <= chr_code;
      col_r  <= chr_col;
      row_r  <= chr_row;
    end
  end
endmodule

// File: tb/tb_fb_text_writer.sv
// Bench for fb_text_writer: command table plus clear/priority/reset sequences,
// RAM writes checked against a scoreboard of expected {cycle, address, data}.
module tb_fb_text_writer;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        chr_valid = 1'b0, clr_valid = 1'b0;
  logic [6:0]  chr_code = '0, chr_col = '0;
  logic [5:0]  chr_row = '0;
  logic        chr_ready, clr_ready, busy, err, wr_en;
  logic [13:0] wr_addr;
  logic [31:0] wr_data;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  typedef struct {
    int          cyc;
    logic [13:0] addr;
    logic [31:0] data;
  } wr_t;
  wr_t sbq[$];

  typedef struct {
    logic [6:0]  code;
    logic [6:0]  col;
    logic [5:0]  row;
    logic        bad;
    logic [13:0] w0;
    logic [31:0] d0;
    logic [31:0] d1;
  } vec_t;
  vec_t vecs[8];

  fb_text_writer dut (
    .CLK_25    (clk),
    .Reset     (rst),
    .chr_valid (chr_valid),
    .chr_ready (chr_ready),
    .chr_code  (chr_code),
    .chr_col   (chr_col),
    .chr_row   (chr_row),
    .clr_valid (clr_valid),
    .clr_ready (clr_ready),
    .busy      (busy),
    .err       (err),
    .WrEn      (wr_en),
    .WrAddress (wr_addr),
    .WrData    (wr_data)
  );

  always #20 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #(40 * 40000);
    $display("FAIL watchdog: simulation still running at cycle %0d, required completion", cyc);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard: every write must match the head entry, and none may be missed.
  always @(negedge clk) begin
    if (!rst) begin
      if (wr_en) begin
        if (sbq.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_write: got addr=%0d data=%h at cycle %0d, required no write",
                   wr_addr, wr_data, cyc);
        end else begin
          wr_t e;
          e = sbq.pop_front();
          check("write", {32'(cyc), 32'(wr_addr), wr_data}, {32'(e.cyc), 32'(e.addr), e.data});
        end
      end else if (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
        wr_t e;
        e = sbq.pop_front();
        check("missing_write", {32'(cyc), 32'(0), 32'(0)}, {32'(e.cyc), 32'(e.addr), e.data});
      end
    end
  end

  task automatic wait_cyc(input int n);
    @(negedge clk);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic send_chr(input vec_t v);
    int acc;
    int guard;
    @(negedge clk);
    chr_code  = v.code;
    chr_col   = v.col;
    chr_row   = v.row;
    chr_valid = 1'b1;
    #1;
    guard = 0;
    while (!chr_ready && guard < 20000) begin
      @(negedge clk);
      #1;
      guard++;
    end
    check("chr_ready_wait", {95'd0, chr_ready}, {95'd0, 1'b1});
    @(posedge clk);
    #1;
    acc       = cyc;
    chr_valid = 1'b0;
    chr_code  = 7'($urandom);
    chr_col   = 7'($urandom);
    chr_row   = 6'($urandom);
    if (v.bad) begin
      wait_cyc(acc);
      check("err_pulse", {94'd0, err, busy}, {94'd0, 1'b1, 1'b0});
      wait_cyc(acc + 1);
      check("err_clear", {94'd0, err, busy}, {94'd0, 1'b0, 1'b0});
    end else begin
      sbq.push_back('{acc + 9, v.w0, v.d0});
      sbq.push_back('{acc + 10, v.w0 + 14'd80, v.d1});
      wait_cyc(acc + 10);
      check("ready_in_wr1", {94'd0, chr_ready, busy}, {94'd0, 1'b0, 1'b1});
      wait_cyc(acc + 11);
      check("ready_after", {94'd0, chr_ready, busy}, {94'd0, 1'b1, 1'b0});
    end
  endtask

  initial begin
    int acc;
    int acc2;
    int bad;
    vec_t hv;

    vecs[0] = '{7'h48,  7'd1,  6'd0, 1'b0, 14'd1,    32'h3F333300, 32'h00333333};
    vecs[1] = '{7'h49,  7'd5,  6'd2, 1'b0, 14'd325,  32'h0C0C1E00, 32'h001E0C0C};
    vecs[2] = '{7'h48,  7'd79, 6'd59, 1'b0, 14'd9519, 32'h3F333300, 32'h00333333};
    vecs[3] = '{7'h48,  7'd80, 6'd0, 1'b1, 14'd0,    32'h0,        32'h0};
    vecs[4] = '{7'h48,  7'd0,  6'd60, 1'b1, 14'd0,   32'h0,        32'h0};
    vecs[5] = '{7'h20,  7'd0,  6'd0, 1'b0, 14'd0,    32'h0,        32'h0};
    vecs[6] = '{7'h49,  7'd40, 6'd30, 1'b0, 14'd4840, 32'h0C0C1E00, 32'h001E0C0C};
    vecs[7] = '{7'h49,  7'd127, 6'd63, 1'b1, 14'd0,  32'h0,        32'h0};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_ctrl", {91'd0, wr_en, busy, chr_ready, clr_ready, err},
          {91'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0});
    check("reset_port", {50'd0, wr_addr, wr_data}, 96'd0);

    for (int i = 0; i < 8; i++) send_chr(vecs[i]);

    // Clear and character requested together: clear first, character held.
    @(negedge clk);
    hv = vecs[0];
    chr_code  = hv.code;
    chr_col   = hv.col;
    chr_row   = hv.row;
    chr_valid = 1'b1;
    clr_valid = 1'b1;
    #1;
    check("prio_ready", {94'd0, chr_ready, clr_ready}, {94'd0, 1'b0, 1'b1});
    @(posedge clk);
    #1;
    acc = cyc;
    clr_valid = 1'b0;
    for (int k = 0; k < 9600; k++) sbq.push_back('{acc + k, 14'(k), 32'h0});
    bad = 0;
    @(negedge clk);
    while (cyc < acc + 9600) begin
      if (chr_ready || clr_ready || !busy) bad++;
      @(negedge clk);
    end
    check("clear_readies_low", 96'(bad), 96'd0);
    check("clear_done", {94'd0, busy, chr_ready}, {94'd0, 1'b0, 1'b1});
    @(posedge clk);
    #1;
    acc2 = cyc;
    chr_valid = 1'b0;
    sbq.push_back('{acc2 + 9, hv.w0, hv.d0});
    sbq.push_back('{acc2 + 10, hv.w0 + 14'd80, hv.d1});
    wait_cyc(acc2 + 11);
    check("held_chr_done", {94'd0, busy, chr_ready}, {94'd0, 1'b0, 1'b1});

    // Reset in the middle of a clear aborts it without waiting for a clock edge.
    @(negedge clk);
    clr_valid = 1'b1;
    @(posedge clk);
    #1;
    acc = cyc;
    clr_valid = 1'b0;
    for (int k = 0; k <= 500; k++) sbq.push_back('{acc + k, 14'(k), 32'h0});
    wait_cyc(acc + 500);
    #1;
    check("mid_clear_addr", 96'(wr_addr), 96'd500);
    rst = 1'b1;
    #1;
    check("reset_abort", {92'd0, wr_en, busy, chr_ready, clr_ready},
          {92'd0, 1'b0, 1'b0, 1'b1, 1'b1});
    sbq.delete();
    @(negedge clk);
    rst = 1'b0;

    hv = '{7'h49, 7'd2, 6'd1, 1'b0, 14'd162, 32'h0C0C1E00, 32'h001E0C0C};
    send_chr(hv);
    repeat (4) @(negedge clk);
    check("scoreboard_empty", 96'(sbq.size()), 96'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/fb_text_writer.md
# fb_text_writer

Character-cell write controller for the 640x480 monochrome framebuffer RAM. Accepts "draw character at (col,row)" and "clear screen" commands, fetches 8 glyph rows from an internal font ROM, and sequences the write port of the dual-port framebuffer RAM. It is the sole write-port owner of that RAM. The VGA read path runs untouched on the read port.

## Interface
Parameters:
- COLS, 80, text columns (one 8-pixel cell per column)
- ROWS, 60, text rows (one 8-line cell per row)
- LINE_WORDS, 80, RAM words per 4-line band (= 640/8)

Ports:
- CLK_25  in  1  pixel/system clock; the block's only clock
- Reset  in  1  asynchronous, active-high reset
- chr_valid  in  1  character command valid
- chr_ready  out  1  character command accepted when valid&ready
- chr_code  in  7  ASCII code, 0..127
- chr_col  in  7  target column
- chr_row  in  6  target row
- clr_valid  in  1  clear-screen command valid
- clr_ready  out  1  clear command accepted when valid&ready
- busy  out  1  high in any state other than IDLE
- err  out  1  one-cycle pulse: out-of-range character command dropped
- WrEn  out  1  RAM write enable
- WrAddress  out  14  RAM word address
- WrData  out  32  RAM write word

## Operation
- RAM layout is fixed: word address = band*80 + cell column, where band = line/4. Byte k of a word holds line (4*band+k). Bit j of that byte is pixel column j of the cell, where j=0 is leftmost.
- A character at (col,row) occupies two words: W0 = row*160 + col holds glyph rows 0..3, and W1 = W0 + 80 holds glyph rows 4..7.
- The font ROM stores the leftmost pixel at the MSB. The controller bit-reverses each byte before packing: WrData[8k+j] = glyph_row[k][7-j].
- States and transitions:
  - IDLE to CLEAR: clr_valid is high.
  - IDLE to FETCH: chr_valid is high and clr_valid is low.
  - FETCH to WR0 after 9 cycles.
  - WR0 to WR1 after 1 cycle.
  - WR1 to IDLE after 1 cycle.
  - CLEAR to IDLE after COLS*ROWS*2 write cycles.
- In IDLE, chr_ready = ~clr_valid and clr_ready = 1. In all other states both readies are 0. Clear therefore wins a simultaneous request, and the character command stays pending.
- Range check happens at acceptance. If chr_col >= COLS or chr_row >= ROWS, the command is consumed, no write occurs, err pulses the next cycle, and the state stays IDLE.
- The command code, col and row are registered at acceptance. Inputs may change freely afterwards.
- FETCH: a 4-bit counter cnt runs 0..8. The ROM address is {code, cnt[2:0]}. ROM data is registered (1-cycle latency) and captured into row buffer [cnt-1] for cnt = 1..8.
- CLEAR: a 14-bit counter runs 0..9599. Each cycle writes WrData = 0 with WrAddress = counter.
- Outside WR0, WR1 and CLEAR: WrEn = 0, WrAddress = 0, WrData = 0.

## Timing
- Reset values (asynchronous): state IDLE, all counters 0, row buffer 0, WrEn/WrAddress/WrData 0, busy 0, err 0. The readies then follow their IDLE rule combinationally.
- Character accepted at edge T:
  - FETCH during cycles T+1..T+9.
  - WR0 (WrEn=1, W0) in cycle T+10.
  - WR1 (W1) in cycle T+11.
  - IDLE with chr_ready high in cycle T+12.
  - Throughput: one character per 12 cycles.
- Clear accepted at edge T: writes in cycles T+1..T+9600, IDLE in cycle T+9601.
- WrEn/WrAddress/WrData are registered outputs, so there is no combinational path from command inputs to the RAM port.
- Reset asserted mid-FETCH, mid-write or mid-CLEAR aborts immediately. Partially written RAM content is left as is.
- Address arithmetic is 14-bit unsigned. The maximum address 9599 fits, with no wrap.

## Structure
- Package fb_pkg holds:
  - FB_COLS, FB_ROWS, FB_LINE_WORDS and FB_CLR_WORDS (= 9600)
  - the state enum fb_wr_state_t {IDLE, FETCH, WR0, WR1, CLEAR}
  - the FB_ADDR_W = 14 and FB_DATA_W = 32 widths
- Sub-module fb_font_rom: 1024x8 synchronous-read ROM (128 glyphs x 8 rows), addressed {code, row}, initialised from the team font table, 1-cycle read latency.
- The top-level instantiates fb_text_writer in place of the current write-port test sequencer.

## Test plan
- Reset: hold Reset, then release. Required: WrEn=0, busy=0, chr_ready=1, clr_ready=1, err=0. Then assert Reset mid-CLEAR at count 500: WrEn drops asynchronously and the state returns to IDLE.
- Glyph 'H' (0x48, rows 00,CC,CC,FC,CC,CC,CC,00) at (1,0). Required: exactly two writes at T+10/T+11, WrAddress 1 then 81, WrData 0x3F333300 then 0x00333333.
- Corner cell: 'H' at (79,59). Required: WrAddress 9519 then 9599, same data as above, chr_ready high at T+12.
- Out-of-range: chr_col=80, chr_row=0. Required: err pulse at T+1, no WrEn, busy stays 0. Repeat with chr_row=60.
- Clear: exactly 9600 consecutive writes, addresses 0..9599 ascending, all data 0, busy low at T+9601.
- Simultaneous clr_valid and chr_valid in IDLE. Required: clear accepted, chr_ready=0 throughout CLEAR, the held character is accepted in the first IDLE cycle after the clear, and its writes follow 10 cycles later.
